// File: rtl/logit_fast.sv
// logit_fast: streaming inverse of the shift-based es=0 posit sigmoid.
// Maps y in (0,1) to x = {~y[N-3], y[N-4:0], 2'b00} through a two-stage
// valid/ready pipeline, flags out-of-domain inputs and counts them.
// Ports:
//   clk_i, rst_n_i         clock, synchronous active-low reset
//   posit_i/valid_i/ready_o  input stream (sigmoid-domain posit y)
//   posit_o/valid_o/ready_i  output stream (pre-activation posit x)
//   err_o                  sideband with posit_o: input was out of domain
//   err_cnt_o/err_clr_i    saturating domain-error count and its clear
module logit_fast #(
  parameter int unsigned POSIT_WIDTH = 16,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [POSIT_WIDTH-1:0] posit_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic [POSIT_WIDTH-1:0] posit_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   err_o,
  output logic [CNT_WIDTH-1:0]   err_cnt_o,
  input  logic                   err_clr_i
);

  localparam int unsigned N = POSIT_WIDTH;
  localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  // Stage 1: raw input plus class
  logic         s1_valid_q, s1_valid_d;
  logic [N-1:0] s1_y_q, s1_y_d;
  logic         s1_nar_q, s1_nar_d;
  logic         s1_err_q, s1_err_d;

  // Stage 2: result
  logic         s2_valid_q, s2_valid_d;
  logic [N-1:0] s2_x_q, s2_x_d;
  logic         s2_err_q, s2_err_d;

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic s1_load, s2_load, accept;
  logic in_nar, in_err;

  // Handshake: each stage loads when it is empty or its successor drains it
  always_comb begin
    s2_load = ~s2_valid_q | ready_i;
    s1_load = ~s1_valid_q | s2_load;
    accept  = valid_i & s1_load;
  end

  // Input classification; zero needs no special case (formula yields NaR)
  always_comb begin
    in_nar = (posit_i == NAR);
    in_err = (posit_i[N-1:N-2] != 2'b00) & ~in_nar;
  end

  // Next-state for both stages
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_y_d     = s1_y_q;
    s1_nar_d   = s1_nar_q;
    s1_err_d   = s1_err_q;
    s2_valid_d = s2_valid_q;
    s2_x_d     = s2_x_q;
    s2_err_d   = s2_err_q;

    if (s1_load) begin
      s1_valid_d = valid_i;
      if (valid_i) begin
        s1_y_d   = posit_i;
        s1_nar_d = in_nar;
        s1_err_d = in_err;
      end
    end

    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_err_d = s1_err_q;
        if (s1_nar_q || s1_err_q) begin
          s2_x_d = NAR;
        end else begin
          s2_x_d = {~s1_y_q[N-3], s1_y_q[N-4:0], 2'b00};
        end
      end
    end
  end

  // Error counter: clear first, then count the word accepted this cycle
  always_comb begin
    cnt_d = cnt_q;
    if (err_clr_i) begin
      cnt_d = (accept && in_err) ? CNT_WIDTH'(1) : '0;
    end else if (accept && in_err && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      s1_valid_q <= 1'b0;
      s1_y_q     <= '0;
      s1_nar_q   <= 1'b0;
      s1_err_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_x_q     <= '0;
      s2_err_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_y_q     <= s1_y_d;
      s1_nar_q   <= s1_nar_d;
      s1_err_q   <= s1_err_d;
      s2_valid_q <= s2_valid_d;
      s2_x_q     <= s2_x_d;
      s2_err_q   <= s2_err_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    ready_o   = s1_load;
    valid_o   = s2_valid_q;
    posit_o   = s2_x_q;
    err_o     = s2_err_q;
    err_cnt_o = cnt_q;
  end

endmodule
